// File: rtl/demux16_pkg.sv
// Shared types and defaults for the demux16 router.
// DEMUX16_CARRY_EN widens each FIFO entry with a carry bit.
package demux16_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 2;

`ifdef DEMUX16_CARRY_EN
    localparam int unsigned CARRY_W = 1;
`else
    localparam int unsigned CARRY_W = 0;
`endif

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

    typedef struct packed {
`ifdef DEMUX16_CARRY_EN
        logic                 carry;
`endif
        logic [WIDTH_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/demux16_fifo.sv
// Synchronous FIFO with power-of-two depth, cleared memory on reset and
// unregistered head output.
module demux16_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even when popping in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/demux16_router.sv
// Registered 1-to-2 demultiplexer with per-channel FIFOs and valid/ready ports.
// DEMUX16_CARRY_EN adds a carry bit that travels with each data word.
module demux16_router
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mod,
`ifdef DEMUX16_CARRY_EN
    input  logic             in_carry,
    output logic             out0_carry,
    output logic             out1_carry,
`endif
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    localparam int unsigned EW = WIDTH + CARRY_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    chan_e         sel;
    logic          acc;
    logic          push0, push1;
    logic          empty0, empty1;
    logic          full0, full1;
    logic          unused_full;
    logic [CW-1:0] count0, count1;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata0, rdata1;

    assign sel      = chan_e'(in_mod);
    assign in_ready = (sel == CH0) ? (count0 < CW'(DEPTH)) : (count1 < CW'(DEPTH));
    assign acc      = in_valid & in_ready;
    assign push0    = acc & (sel == CH0);
    assign push1    = acc & (sel == CH1);

`ifdef DEMUX16_CARRY_EN
    assign wdata      = {in_carry, in_data};
    assign out0_carry = rdata0[WIDTH];
    assign out1_carry = rdata1[WIDTH];
`else
    assign wdata      = in_data;
`endif

    assign out0_valid  = ~empty0;
    assign out1_valid  = ~empty1;
    assign out0_data   = rdata0[WIDTH-1:0];
    assign out1_data   = rdata1[WIDTH-1:0];
    assign unused_full = full0 ^ full1;

    demux16_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .wdata (wdata),
        .pop   (out0_ready),
        .rdata (rdata0),
        .full  (full0),
        .empty (empty0),
        .count (count0)
    );

    demux16_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .wdata (wdata),
        .pop   (out1_ready),
        .rdata (rdata1),
        .full  (full1),
        .empty (empty1),
        .count (count1)
    );

endmodule

// File: tb/tb_demux16_router.sv
// Directed self-checking bench for demux16_router; honours DEMUX16_CARRY_EN.
module tb_demux16_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_mod;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [15:0] out0_data, out1_data;
`ifdef DEMUX16_CARRY_EN
    logic        in_carry;
    logic        out0_carry, out1_carry;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux16_router #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mod     (in_mod),
`ifdef DEMUX16_CARRY_EN
        .in_carry   (in_carry),
        .out0_carry (out0_carry),
        .out1_carry (out1_carry),
`endif
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mod     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
`ifdef DEMUX16_CARRY_EN
        in_carry   = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        #1;

        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", 32'(out0_data), 32'h0);
        check("rst_out1_data", 32'(out1_data), 32'h0);
        check("rst_in_ready_m0", 32'(in_ready), 32'd1);
        in_mod = 1'b1;
        #1;
        check("rst_in_ready_m1", 32'(in_ready), 32'd1);
`ifdef DEMUX16_CARRY_EN
        check("rst_out0_carry", 32'(out0_carry), 32'd0);
        check("rst_out1_carry", 32'(out1_carry), 32'd0);
`endif

        // Single word to channel 0
        in_valid = 1'b1; in_mod = 1'b0; in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        #1;
        check("t1_out0_valid", 32'(out0_valid), 32'd1);
        check("t1_out0_data", 32'(out0_data), 32'h1234);
        check("t1_out1_valid", 32'(out1_valid), 32'd0);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        check("t1_drained", 32'(out0_valid), 32'd0);

        // Fill channel 0 under backpressure; channel 1 must stay open
        in_valid = 1'b1; in_mod = 1'b0; in_data = 16'hAAAA;
        #1;
        check("t2_rdy_aaaa", 32'(in_ready), 32'd1);
        step();
        in_data = 16'h5555;
        #1;
        check("t2_rdy_5555", 32'(in_ready), 32'd1);
        step();
        in_data = 16'h0F0F;
        #1;
        check("t2_full_rdy", 32'(in_ready), 32'd0);
        step();
        in_mod = 1'b1; in_data = 16'hBEEF;
        #1;
        check("t2_ch1_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("t2_out1_valid", 32'(out1_valid), 32'd1);
        check("t2_out1_data", 32'(out1_data), 32'hBEEF);
        check("t2_out0_head", 32'(out0_data), 32'hAAAA);

        // Full channel 0 with simultaneous pop: push refused this cycle only
        in_valid = 1'b1; in_mod = 1'b0; in_data = 16'h0001; out0_ready = 1'b1;
        #1;
        check("t3_full_pop_rdy", 32'(in_ready), 32'd0);
        check("t3_rd_aaaa", 32'(out0_data), 32'hAAAA);
        step();
        out0_ready = 1'b0;
        #1;
        check("t3_rdy_next", 32'(in_ready), 32'd1);
        check("t3_head_5555", 32'(out0_data), 32'h5555);
        step();
        in_valid = 1'b0; out0_ready = 1'b1;
        #1;
        check("t3_rd_5555", 32'(out0_data), 32'h5555);
        step();
        check("t3_rd_0001", 32'(out0_data), 32'h0001);
        check("t3_valid_0001", 32'(out0_valid), 32'd1);
        step();
        out0_ready = 1'b0;
        check("t3_ch0_empty", 32'(out0_valid), 32'd0);
        out1_ready = 1'b1;
        step();
        check("t3_ch1_empty", 32'(out1_valid), 32'd0);

        // Continuous stream to channel 1 with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mod = 1'b1; in_data = 16'(i);
            #1;
            check("t4_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check("t4_out1_valid", 32'(out1_valid), 32'd1);
                check("t4_out1_data", 32'(out1_data), 32'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("t4_last_data", 32'(out1_data), 32'd9);
        check("t4_last_valid", 32'(out1_valid), 32'd1);
        step();
        out1_ready = 1'b0;
        check("t4_drained", 32'(out1_valid), 32'd0);

        // Reset with both FIFOs holding data and a push pending
        in_valid = 1'b1; in_mod = 1'b0; in_data = 16'h1111;
        step();
        in_mod = 1'b1; in_data = 16'h2222;
        step();
        in_mod = 1'b0; in_data = 16'h3333; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_out0_valid", 32'(out0_valid), 32'd0);
        check("t5_out1_valid", 32'(out1_valid), 32'd0);
        check("t5_out0_data", 32'(out0_data), 32'h0);
        check("t5_out1_data", 32'(out1_data), 32'h0);
        check("t5_in_ready_m0", 32'(in_ready), 32'd1);
        in_mod = 1'b1;
        #1;
        check("t5_in_ready_m1", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_mod = 1'b0; in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        #1;
        check("t5_fresh_data", 32'(out0_data), 32'h7777);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        check("t5_fresh_gone", 32'(out0_valid), 32'd0);
        check("t5_no_stale", 32'(out0_data), 32'h0);

`ifdef DEMUX16_CARRY_EN
        // Carry travels with its word
        in_valid = 1'b1; in_mod = 1'b1; in_data = 16'hFFFF; in_carry = 1'b1;
        step();
        in_data = 16'h0000; in_carry = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        check("t6_data_ffff", 32'(out1_data), 32'hFFFF);
        check("t6_carry_1", 32'(out1_carry), 32'd1);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check("t6_data_0000", 32'(out1_data), 32'h0000);
        check("t6_carry_0", 32'(out1_carry), 32'd0);
        check("t6_valid", 32'(out1_valid), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux16_router.md
# demux16_router

Registered 1-to-2 demultiplexer for 16-bit adder results, with a valid/ready handshake on every port. It is the distribution-side counterpart to the result-select muxes in the carry-select adder datapath. Each word accepted on the input is steered by `in_mod` into one of two per-channel FIFOs, and each FIFO drains independently to its consumer. Backpressure on one channel never blocks words bound for the other channel.

## Interface
- `WIDTH`, 16: data width of every data port.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the input word is present.
- `in_ready` output 1: the input word is accepted this cycle when `in_valid` is also high.
- `in_data` input WIDTH: the result word.
- `in_mod` input 1: destination channel; 0 selects channel 0, 1 selects channel 1.
- `out0_valid`, `out1_valid` output 1: the channel FIFO is non-empty.
- `out0_ready`, `out1_ready` input 1: the consumer takes the head word.
- `out0_data`, `out1_data` output WIDTH: the channel head word.

## Operation
- Input accept condition: `acc = in_valid & in_ready`.
- `in_ready` is combinational: the `in_mod`-selected FIFO count is less than DEPTH. It does not depend on either `outN_ready`; there is no full-FIFO bypass.
- Push rule: on `acc`, `in_data` is written to FIFO[`in_mod`] at its write pointer. The write pointer and count increment.
- Pop rule: on `outN_valid & outN_ready`, the channel read pointer increments and the count decrements.
- Simultaneous push and pop on the same channel: the count is unchanged and both pointers advance.
  - This applies to a non-full FIFO.
  - A full FIFO cannot push in that cycle, even while popping.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- `outN_valid` = (countN != 0).
- `outN_data` = memN[rd_ptrN], with no output register.
- Ordering:
  - Within a channel, words leave in strict input order.
  - There is no ordering guarantee across channels.
- Protocol obligations:
  - The upstream holds `in_data` and `in_mod` stable while `in_valid` is high and `in_ready` is low.
  - The block holds `outN_data` stable while `outN_valid` is high and `outN_ready` is low.
- Reset (`rst` high at an edge):
  - Pointers and counts go to 0 and memory entries to 0. Queued words are discarded.
  - Outputs after reset: `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`. `in_ready = 1` for either `in_mod`.
  - Reset overrides any push or pop in the same cycle.

## Timing
- Latency: a word accepted at edge N is visible on `outN_valid`/`outN_data` after edge N, i.e. in the next cycle.
- Throughput: one word per cycle per channel. Input throughput is one word per cycle while the target FIFO is not full.
- `in_ready` to `in_valid`: there is no combinational path.
- `in_mod` to `in_ready`: there is one combinational path.

## Configuration
- Macro `DEMUX16_CARRY_EN`, when defined:
  - Adds the port `in_carry` (input 1) and the ports `out0_carry` / `out1_carry` (output 1).
  - Each FIFO entry becomes WIDTH+1 bits. The carry bit travels with its data word, with identical latency and ordering.
  - `outN_carry` resets to 0.
- When the macro is undefined, the carry ports and carry storage are absent and behaviour is otherwise identical.

## Structure
- Package `demux16_pkg`:
  - `WIDTH_DEF = 16`, `DEPTH_DEF = 2`.
  - Typedef `chan_e` {CH0=0, CH1=1}.
  - Entry typedef `entry_t`, which includes the carry bit under `DEMUX16_CARRY_EN`.
- Sub-module `demux16_fifo`: synchronous FIFO with push/pop/full/empty/count ports. It is instantiated twice.
- The top level contains only steering, `in_ready` selection, and reset fan-out.

## Test plan
- Reset, then push `0x1234` with `in_mod=0`:
  - `out0_valid = 1` the next cycle, `out0_data = 0x1234`.
  - `out1_valid` stays 0.
- Hold `out0_ready = 0` and push `0xAAAA`, then `0x5555`, both to channel 0:
  - Both are accepted, after which `in_ready = 0` for `in_mod = 0`.
  - A third word `0x0F0F` to channel 0 is not accepted.
  - A push of `0xBEEF` with `in_mod = 1` is still accepted.
- Channel 0 full and `out0_ready = 1` while pushing `0x0001` to channel 0:
  - The push is refused that cycle and accepted the next.
  - Read order is `0xAAAA`, `0x5555`, `0x0001`.
- Continuous stream to channel 1 with `out1_ready = 1`, values 0..9:
  - One word per cycle.
  - `out1_data` shows 0..9 in order, one cycle behind the input; count stays ≤ 1.
- Assert `rst` with both FIFOs holding data:
  - Next cycle `out0_valid = out1_valid = 0`, data 0, `in_ready = 1`.
  - A subsequent push of `0x7777` returns `0x7777`, not stale data.
- With `DEMUX16_CARRY_EN` defined, push `0xFFFF` with carry 1 and then `0x0000` with carry 0 to channel 1:
  - `out1_carry` reads 1 then 0, aligned with its data.
